// File: rtl/fft_pkg.sv
// Shared types for the FFT, magnitude and peak-detect stages.
// Holds the frame-tracking state enum and the bin-index width helper.
package fft_pkg;

   typedef enum logic {
      SCAN   = 1'b0,
      RESYNC = 1'b1
   } fft_state_t;

   function automatic int bin_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fft_peak_detect.sv
// Per-frame peak search over squared FFT magnitudes, with frame-length policing.
// Optional FFT_PEAK_HOLD_EN adds a decaying held-peak output (peak_hold).
module fft_peak_detect
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int FFT_SIZE    = 1024,
   parameter int MIN_BIN     = 1,
   parameter int DECAY_SHIFT = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [2*DATA_WIDTH-1:0]       mag_squared,
   input  logic                          mag_valid,
   input  logic                          mag_last,
   output logic [2*DATA_WIDTH-1:0]       peak_mag,
   output logic [bin_width(FFT_SIZE)-1:0] peak_bin,
   output logic                          peak_valid,
`ifdef FFT_PEAK_HOLD_EN
   output logic [2*DATA_WIDTH-1:0]       peak_hold,
`endif
   output logic                          frame_err
);

   localparam int MW = 2 * DATA_WIDTH;
   localparam int BW = bin_width(FFT_SIZE);
   localparam logic [BW-1:0] LAST_BIN = BW'(FFT_SIZE - 1);
   localparam logic [BW-1:0] LO_BIN   = BW'(MIN_BIN);
   localparam logic [BW-1:0] HI_BIN   = BW'(FFT_SIZE / 2 - 1);

   fft_state_t      r_state;
   fft_state_t      w_state_nxt;
   logic [BW-1:0]   r_cnt;
   logic [MW-1:0]   r_max;
   logic [BW-1:0]   r_max_bin;

   logic            w_good;
   logic            w_err;
   logic            w_clr;
   logic            w_inc;
   logic            w_load;
   logic            w_upd;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= SCAN;
      else     r_state <= w_state_nxt;
   end

   // Next-state and per-beat control decode
   always_comb begin
      w_state_nxt = r_state;
      w_good      = 1'b0;
      w_err       = 1'b0;
      w_clr       = 1'b0;
      w_inc       = 1'b0;
      w_load      = 1'b0;
      w_upd       = 1'b0;
      if (mag_valid) begin
         unique case (r_state)
            SCAN: begin
               if (mag_last) begin
                  w_clr = 1'b1;
                  if (r_cnt == LAST_BIN) w_good = 1'b1;
                  else                   w_err  = 1'b1;
               end else if (r_cnt == LAST_BIN) begin
                  w_err       = 1'b1;
                  w_clr       = 1'b1;
                  w_state_nxt = RESYNC;
               end else begin
                  w_inc = 1'b1;
                  if (r_cnt == LO_BIN) begin
                     w_load = 1'b1;
                  end else if (r_cnt > LO_BIN && r_cnt <= HI_BIN
                               && mag_squared > r_max) begin
                     w_upd = 1'b1;
                  end
               end
            end
            RESYNC: begin
               if (mag_last) begin
                  w_clr       = 1'b1;
                  w_state_nxt = SCAN;
               end
            end
            default: w_state_nxt = SCAN;
         endcase
      end
   end

   // Bin counter: advances only on accepted beats
   always_ff @(posedge clk) begin
      if (rst)        r_cnt <= '0;
      else if (w_clr) r_cnt <= '0;
      else if (w_inc) r_cnt <= r_cnt + 1'b1;
   end

   // Running maximum; strict compare keeps the lowest bin on ties
   always_ff @(posedge clk) begin
      if (rst || w_good) begin
         r_max     <= '0;
         r_max_bin <= '0;
      end else if (w_load || w_upd) begin
         r_max     <= mag_squared;
         r_max_bin <= r_cnt;
      end
   end

   // Result registers and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         peak_mag   <= '0;
         peak_bin   <= '0;
         peak_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         peak_valid <= w_good;
         frame_err  <= w_err;
         if (w_good) begin
            peak_mag <= r_max;
            peak_bin <= r_max_bin;
         end
      end
   end

`ifdef FFT_PEAK_HOLD_EN
   logic [MW-1:0] r_hold;
   logic [MW-1:0] w_hold_dec;

   assign w_hold_dec = r_hold - (r_hold >> DECAY_SHIFT);
   assign peak_hold  = r_hold;

   // Held peak decays once per published frame, refreshed by larger peaks
   always_ff @(posedge clk) begin
      if (rst)         r_hold <= '0;
      else if (w_good) r_hold <= (r_max > w_hold_dec) ? r_max : w_hold_dec;
   end
`else
   logic w_unused_decay;
   assign w_unused_decay = ^DECAY_SHIFT;
`endif

endmodule
